// File: rtl/instr_fetch_sequencer_if.sv
// Bus between the PC/program loader and the instruction fetch sequencer.
// The master side drives the fetch address and the program-load port. The slave side returns the decoded instruction and the strobes.
interface instr_fetch_sequencer_if #(
    parameter int ADDR_W  = 5,
    parameter int INSTR_W = 16
);
    logic [ADDR_W-1:0]  address;
    logic               prog_we;
    logic [ADDR_W-1:0]  prog_addr;
    logic [INSTR_W-1:0] prog_data;
    logic [INSTR_W-1:0] instr;
    logic [3:0]         func;
    logic [3:0]         rd;
    logic [3:0]         rs;
    logic [3:0]         rt;
    logic               alu_en;
    logic               reg_we;
    logic [2:0]         phase;
    logic               halted;

    modport master (
        output address, prog_we, prog_addr, prog_data,
        input  instr, func, rd, rs, rt, alu_en, reg_we, phase, halted
    );

    modport slave (
        input  address, prog_we, prog_addr, prog_data,
        output instr, func, rd, rs, rt, alu_en, reg_we, phase, halted
    );
endinterface

// File: rtl/instr_fetch_sequencer.sv
// Instruction store, instruction register and phase sequencer for the simple processor.
// Single-cycle ops take one clock. Multi-cycle ops take five clocks: FETCH, EXEC0-2, WB.
module instr_fetch_sequencer #(
    parameter int         ADDR_W    = 5,
    parameter int         INSTR_W   = 16,
    parameter logic [3:0] MC_THRESH = 4'b0010
) (
    input logic                   clk,
    input logic                   rst,
    instr_fetch_sequencer_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        FETCH = 3'd0,
        EXEC0 = 3'd1,
        EXEC1 = 3'd2,
        EXEC2 = 3'd3,
        WB    = 3'd4,
        HALT  = 3'd7
    } phase_t;

    logic [INSTR_W-1:0] mem [DEPTH];
    logic [INSTR_W-1:0] instr_q;
    logic [INSTR_W-1:0] fetch_word;
    logic [3:0]         fetch_func;
    phase_t             state;
    logic               alu_en_q;
    logic               reg_we_q;
    logic               halted_q;

    // The store has no reset, so a preloaded program survives rst.
    always_ff @(posedge clk) begin
        if (bus.prog_we)
            mem[bus.prog_addr] <= bus.prog_data;
    end

    // The read is combinational and the store updates on the edge, so a same-cycle write returns the old word.
    assign fetch_word = mem[bus.address];
    assign fetch_func = fetch_word[INSTR_W-1 -: 4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FETCH;
            instr_q  <= '0;
            alu_en_q <= 1'b0;
            reg_we_q <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    instr_q <= fetch_word;
                    if (fetch_func == 4'hF) begin
                        state    <= HALT;
                        halted_q <= 1'b1;
                        alu_en_q <= 1'b0;
                        reg_we_q <= 1'b0;
                    end else if (fetch_func < MC_THRESH) begin
                        state    <= FETCH;
                        alu_en_q <= 1'b0;
                        reg_we_q <= 1'b1;
                    end else begin
                        state    <= EXEC0;
                        alu_en_q <= 1'b1;
                        reg_we_q <= 1'b0;
                    end
                end
                EXEC0: begin
                    state    <= EXEC1;
                    alu_en_q <= 1'b1;
                    reg_we_q <= 1'b0;
                end
                EXEC1: begin
                    state    <= EXEC2;
                    alu_en_q <= 1'b1;
                    reg_we_q <= 1'b0;
                end
                EXEC2: begin
                    state    <= WB;
                    alu_en_q <= 1'b0;
                    reg_we_q <= 1'b1;
                end
                WB: begin
                    state    <= FETCH;
                    alu_en_q <= 1'b0;
                    reg_we_q <= 1'b0;
                end
                HALT: begin
                    state    <= HALT;
                    alu_en_q <= 1'b0;
                    reg_we_q <= 1'b0;
                    halted_q <= 1'b1;
                end
                default: begin
                    state    <= FETCH;
                    alu_en_q <= 1'b0;
                    reg_we_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.instr  = instr_q;
    assign bus.func   = instr_q[15:12];
    assign bus.rd     = instr_q[11:8];
    assign bus.rs     = instr_q[7:4];
    assign bus.rt     = instr_q[3:0];
    assign bus.alu_en = alu_en_q;
    assign bus.reg_we = reg_we_q;
    assign bus.phase  = state;
    assign bus.halted = halted_q;
endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Directed and randomized checks of instr_fetch_sequencer.
// A reference model tracks each instruction's position in its clock budget.
module tb_instr_fetch_sequencer;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    instr_fetch_sequencer_if #(.ADDR_W(5), .INSTR_W(16)) bus ();

    instr_fetch_sequencer #(.ADDR_W(5), .INSTR_W(16), .MC_THRESH(4'b0010)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model. m_pos counts clocks into a multi-cycle instruction (0 = ready to fetch).
    logic [15:0] m_mem [32];
    logic [15:0] m_instr;
    int          m_pos;
    bit          m_halt;
    bit          m_we;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_instr = '0;
        m_pos   = 0;
        m_halt  = 1'b0;
        m_we    = 1'b0;
    endtask

    task automatic model_edge();
        logic [15:0] w;
        if (!rst && !m_halt) begin
            if (m_pos == 0) begin
                w       = m_mem[bus.address];
                m_instr = w;
                if (w[15:12] == 4'hF) begin
                    m_halt = 1'b1;
                    m_we   = 1'b0;
                end else if (w[15:12] < 4'd2) begin
                    m_we = 1'b1;
                end else begin
                    m_pos = 1;
                    m_we  = 1'b0;
                end
            end else begin
                m_pos = (m_pos == 4) ? 0 : m_pos + 1;
                m_we  = (m_pos == 4);
            end
        end
        if (bus.prog_we)
            m_mem[bus.prog_addr] = bus.prog_data;
    endtask

    task automatic compare_all();
        chk("phase",  32'(bus.phase),  m_halt ? 32'd7 : 32'(m_pos));
        chk("instr",  32'(bus.instr),  32'(m_instr));
        chk("func",   32'(bus.func),   32'(m_instr[15:12]));
        chk("rd",     32'(bus.rd),     32'(m_instr[11:8]));
        chk("rs",     32'(bus.rs),     32'(m_instr[7:4]));
        chk("rt",     32'(bus.rt),     32'(m_instr[3:0]));
        chk("alu_en", 32'(bus.alu_en), 32'(!m_halt && m_pos >= 1 && m_pos <= 3));
        chk("reg_we", 32'(bus.reg_we), 32'(m_we));
        chk("halted", 32'(bus.halted), 32'(m_halt));
        chk("excl",   32'(bus.alu_en & bus.reg_we), 32'd0);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic async_reset();
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
    endtask

    logic [4:0]  ld_addr [7];
    logic [15:0] ld_data [7];
    logic [2:0]  exp_ph  [5];
    int          alu_cnt;
    logic [15:0] held;

    initial begin
        n_chk = 0;
        n_err = 0;
        bus.address   = '0;
        bus.prog_we   = 1'b0;
        bus.prog_addr = '0;
        bus.prog_data = '0;
        for (int i = 0; i < 32; i++) m_mem[i] = 16'h0000;
        ld_addr = '{5'd3, 5'd5, 5'd7, 5'd9, 5'd31, 5'd0, 5'd1};
        ld_data = '{16'h1234, 16'h2ABC, 16'h0AAA, 16'hF000, 16'h0131, 16'h1000, 16'h0000};

        // Reset state, then preload the store while reset is held.
        async_reset();
        for (int i = 0; i < 7; i++) begin
            bus.prog_we   = 1'b1;
            bus.prog_addr = ld_addr[i];
            bus.prog_data = ld_data[i];
            cyc();
        end
        bus.prog_we = 1'b0;
        rst = 1'b0;
        cyc();

        // Single-cycle op decode.
        bus.address = 5'd3;
        cyc();
        chk("t2_func", 32'(bus.func), 32'd1);
        chk("t2_rd", 32'(bus.rd), 32'd2);
        chk("t2_rs", 32'(bus.rs), 32'd3);
        chk("t2_rt", 32'(bus.rt), 32'd4);
        chk("t2_we", 32'(bus.reg_we), 32'd1);
        chk("t2_phase", 32'(bus.phase), 32'd0);

        // Multi-cycle op. The address is moved to HALT during EXEC to prove it is ignored.
        exp_ph  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
        alu_cnt = 0;
        bus.address = 5'd5;
        for (int i = 0; i < 5; i++) begin
            cyc();
            bus.address = 5'd9;
            chk("t3_phase", 32'(bus.phase), 32'(exp_ph[i]));
            chk("t3_we", 32'(bus.reg_we), 32'(i == 3));
            alu_cnt += int'(bus.alu_en);
        end
        chk("t3_alu_cycles", 32'(alu_cnt), 32'd3);

        // Reset in the middle of EXEC1. The store must keep its contents.
        bus.address = 5'd5;
        cyc();
        cyc();
        chk("t1_in_exec1", 32'(bus.phase), 32'd2);
        async_reset();
        chk("t1_phase", 32'(bus.phase), 32'd0);
        chk("t1_instr", 32'(bus.instr), 32'd0);
        cyc();
        rst = 1'b0;
        bus.address = 5'd3;
        cyc();
        chk("t1_mem_kept", 32'(bus.instr), 32'h1234);

        // A write and a fetch of the same address in one cycle return the old word.
        bus.address   = 5'd7;
        bus.prog_we   = 1'b1;
        bus.prog_addr = 5'd7;
        bus.prog_data = 16'h0001;
        cyc();
        bus.prog_we = 1'b0;
        chk("t4_old", 32'(bus.instr), 32'h0AAA);
        cyc();
        chk("t4_new", 32'(bus.instr), 32'h0001);

        // The address wraps from 31 to 0.
        bus.address = 5'd31;
        cyc();
        chk("t6_31", 32'(bus.instr), 32'h0131);
        bus.address = 5'd0;
        cyc();
        chk("t6_0", 32'(bus.instr), 32'h1000);

        // HALT holds until reset. prog_we is still accepted while halted.
        bus.address = 5'd9;
        cyc();
        chk("t5_phase", 32'(bus.phase), 32'd7);
        chk("t5_halted", 32'(bus.halted), 32'd1);
        held = bus.instr;
        for (int i = 0; i < 4; i++) begin
            bus.address = 5'(i * 7 + 1);
            bus.prog_we = (i == 2);
            bus.prog_addr = 5'd20;
            bus.prog_data = 16'h1555;
            cyc();
            chk("t5_hold", 32'(bus.instr), 32'(held));
        end
        bus.prog_we = 1'b0;
        async_reset();
        chk("t5_cleared", 32'(bus.halted), 32'd0);
        cyc();
        rst = 1'b0;
        bus.address = 5'd20;
        cyc();
        chk("t5_write_in_halt", 32'(bus.instr), 32'h1555);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            bus.address   = 5'($urandom);
            bus.prog_we   = ($urandom_range(0, 2) == 0);
            bus.prog_addr = 5'($urandom);
            bus.prog_data = 16'($urandom);
            if ($urandom_range(0, 30) == 0) begin
                async_reset();
                cyc();
                rst = 1'b0;
            end else begin
                cyc();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
